// File: rtl/out_uart_tx.sv
// Byte FIFO plus 8N1 UART transmitter fed by the core's out_en/out_data strobe.
// The core cannot be stalled, so a byte that finds the FIFO full is dropped and flagged.
module out_uart_tx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     out_en,
    input  logic [7:0]               out_data,
    output logic                     txd,
    output logic                     busy,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int TW    = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("out_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   bit_timer_q, bit_timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      fifo_mem_q [DEPTH];

    logic timer_last;
    logic fifo_nonempty;
    logic pop;
    logic push;

    // A pop frees a slot at the same edge, so a full FIFO still accepts a byte on a pop edge.
    always_comb begin
        timer_last    = (bit_timer_q == TIMER_LAST);
        fifo_nonempty = (count_q != '0);
        pop           = fifo_nonempty &&
                        ((state_q == IDLE) || ((state_q == STOP) && timer_last));
        push          = out_en && ((count_q < DEPTH_C) || pop);
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        bit_timer_d = timer_last ? '0 : bit_timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                bit_timer_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (timer_last) begin
                    state_d   = DATA;
                    txd_d     = shift_q[0];
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (timer_last) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (timer_last) begin
                    if (pop) begin
                        state_d = START;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d   = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        overflow_d = overflow_q | (out_en & ~push);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_timer_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_timer_q <= bit_timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem_q[wr_ptr_q] <= out_data;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || fifo_nonempty;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a queue-based transmitter model checked every cycle,
// plus an independent line receiver that decodes the frames on txd.
module tb_out_uart_tx;

    localparam int C     = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          out_en   = 1'b0;
    logic [7:0]    out_data = 8'h00;
    logic          txd;
    logic          busy;
    logic          overflow;
    logic [DL:0]   fifo_count;

    out_uart_tx #(
        .CLKS_PER_BIT    (C),
        .FIFO_DEPTH_LOG2 (DL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .out_en     (out_en),
        .out_data   (out_data),
        .txd        (txd),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;
    bit mon_en        = 1'b0;

    // Reference model: a byte queue plus "which cycle of the current 10-bit frame are we in".
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_pos = 0;
    bit         m_ovf = 1'b0;
    bit         m_pop = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * C) m_active = 1'b0;
            end
            m_pop = !m_active && (m_q.size() != 0);
            if (out_en) begin
                if (m_q.size() < DEPTH || m_pop) m_q.push_back(out_data);
                else m_ovf = 1'b1;
            end
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_sent.push_back(m_cur);
                m_active = 1'b1;
                m_pos    = 0;
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            checks_total++;
            if (txd !== exp_txd()) $display("[TB] FAIL txd @%0t: got %b expected %b", $time, txd, exp_txd());
            else checks_passed++;
            checks_total++;
            if (busy !== (m_active || m_q.size() != 0))
                $display("[TB] FAIL busy @%0t: got %b expected %b", $time, busy, (m_active || m_q.size() != 0));
            else checks_passed++;
            checks_total++;
            if (overflow !== m_ovf) $display("[TB] FAIL overflow @%0t: got %b expected %b", $time, overflow, m_ovf);
            else checks_passed++;
            checks_total++;
            if (fifo_count !== (DL+1)'(m_q.size()))
                $display("[TB] FAIL fifo_count @%0t: got %0d expected %0d", $time, fifo_count, m_q.size());
            else checks_passed++;
        end
    end

    // Independent line receiver: samples mid-bit, discards frames that a reset interrupted.
    logic [7:0] rx_q[$];
    int         reset_edges = 0;

    always @(posedge clock) if (reset) reset_edges++;

    initial begin : receiver
        logic [7:0] b;
        logic       stop_bit;
        int         rst_mark;
        forever begin
            @(negedge clock);
            if (mon_en && txd === 1'b0) begin
                rst_mark = reset_edges;
                repeat (C/2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clock);
                    b[i] = txd;
                end
                repeat (C) @(negedge clock);
                stop_bit = txd;
                if (rst_mark == reset_edges && stop_bit === 1'b1) rx_q.push_back(b);
            end
        end
    end

    task automatic drive_cycle(input logic en, input logic [7:0] data);
        out_en   = en;
        out_data = data;
        @(negedge clock);
        out_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks_total++;
        if ({txd, busy, overflow, fifo_count} !== {1'b1, 1'b0, 1'b0, 5'd0})
            $display("[TB] FAIL reset_values: got txd=%b busy=%b ovf=%b cnt=%0d expected 1 0 0 0",
                     txd, busy, overflow, fifo_count);
        else checks_passed++;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_byte();
        bit to;
        int n;
        int rb = rx_q.size();
        drive_cycle(1'b1, 8'h41);
        checks_total++;
        if (txd !== 1'b1 || fifo_count !== 5'd1)
            $display("[TB] FAIL single_push_edge: got txd=%b cnt=%0d expected 1 1", txd, fifo_count);
        else checks_passed++;
        @(negedge clock);
        checks_total++;
        if (txd !== 1'b0) $display("[TB] FAIL single_latency: got txd=%b expected 0", txd);
        else checks_passed++;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks_total++;
        if (n != 40) $display("[TB] FAIL single_busy_len: got %0d expected 40", n);
        else checks_passed++;
        wait_idle(50, to);
        checks_total++;
        if (to || rx_q.size() != rb + 1 || rx_q[rb] !== 8'h41)
            $display("[TB] FAIL single_decode: got %0d bytes expected 1 byte 41", rx_q.size() - rb);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        int peak = 0;
        int rb = rx_q.size();
        drive_cycle(1'b1, 8'h48);
        drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, 8'h69);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (busy === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        checks_total++;
        if (to) $display("[TB] FAIL b2b_timeout: got busy stuck expected idle");
        else checks_passed++;
        checks_total++;
        if (peak != 1) $display("[TB] FAIL b2b_peak_count: got %0d expected 1", peak);
        else checks_passed++;
        checks_total++;
        if (rx_q.size() != rb + 2 || rx_q[rb] !== 8'h48 || rx_q[rb+1] !== 8'h69)
            $display("[TB] FAIL b2b_decode: got %0d bytes expected \"Hi\"", rx_q.size() - rb);
        else checks_passed++;
    endtask

    task automatic test_overflow();
        bit to;
        int rb = rx_q.size();
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 8'(i));
        checks_total++;
        if (overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", overflow);
        else checks_passed++;
        wait_idle(1500, to);
        checks_total++;
        if (to || rx_q.size() != rb + 17)
            $display("[TB] FAIL ovf_count: got %0d bytes expected 17", rx_q.size() - rb);
        else checks_passed++;
        for (int i = 0; i < 17 && rb + i < rx_q.size(); i++) begin
            checks_total++;
            if (rx_q[rb+i] !== 8'(i)) $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, rx_q[rb+i], 8'(i));
            else checks_passed++;
        end
        checks_total++;
        if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow);
        else checks_passed++;
    endtask

    task automatic test_full_pop_edge();
        bit to;
        int rb;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rb = rx_q.size();
        for (int i = 0; i < 17; i++) drive_cycle(1'b1, 8'($urandom));
        repeat (24) drive_cycle(1'b0, 8'h00);
        checks_total++;
        if (fifo_count !== 5'd16) $display("[TB] FAIL full_before_pop: got %0d expected 16", fifo_count);
        else checks_passed++;
        drive_cycle(1'b1, 8'hA5);
        checks_total++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0)
            $display("[TB] FAIL full_pop_push: got cnt=%0d ovf=%b expected 16 0", fifo_count, overflow);
        else checks_passed++;
        wait_idle(1500, to);
        checks_total++;
        if (to || rx_q.size() != rb + 18 || rx_q[rb+17] !== 8'hA5)
            $display("[TB] FAIL full_decode: got %0d bytes expected 18 ending A5", rx_q.size() - rb);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int rb;
        logic [7:0] nb;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'($urandom));
        repeat (14) drive_cycle(1'b0, 8'h00);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks_total++;
        if ({txd, busy, overflow, fifo_count} !== {1'b1, 1'b0, 1'b0, 5'd0})
            $display("[TB] FAIL midframe_reset: got txd=%b busy=%b ovf=%b cnt=%0d expected 1 0 0 0",
                     txd, busy, overflow, fifo_count);
        else checks_passed++;
        repeat (50) @(negedge clock);
        rb = rx_q.size();
        nb = 8'($urandom);
        drive_cycle(1'b1, nb);
        @(negedge clock);
        wait_idle(100, to);
        checks_total++;
        if (to || rx_q.size() != rb + 1 || rx_q[rb] !== nb)
            $display("[TB] FAIL midframe_after: got %0d bytes expected 1 byte %h", rx_q.size() - rb, nb);
        else checks_passed++;
    endtask

    task automatic test_pointer_wrap();
        bit to;
        logic [7:0] exp[$];
        int rb = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            exp.push_back(8'($urandom));
            drive_cycle(1'b1, exp[i]);
            repeat (47) @(negedge clock);
        end
        wait_idle(200, to);
        checks_total++;
        if (to || rx_q.size() != rb + 40)
            $display("[TB] FAIL wrap_count: got %0d bytes expected 40", rx_q.size() - rb);
        else checks_passed++;
        for (int i = 0; i < 40 && rb + i < rx_q.size(); i++) begin
            checks_total++;
            if (rx_q[rb+i] !== exp[i]) $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", i, rx_q[rb+i], exp[i]);
            else checks_passed++;
        end
        checks_total++;
        if (overflow !== 1'b0) $display("[TB] FAIL wrap_overflow: got %b expected 0", overflow);
        else checks_passed++;
    endtask

    task automatic test_random_traffic();
        bit to;
        int rb = rx_q.size();
        int sb = m_sent.size();
        for (int i = 0; i < 600; i++)
            drive_cycle(($urandom_range(0, 15) < 2) || (i > 300 && i < 330), 8'($urandom));
        wait_idle(1500, to);
        checks_total++;
        if (to || (rx_q.size() - rb) != (m_sent.size() - sb))
            $display("[TB] FAIL rand_count: got %0d bytes expected %0d", rx_q.size() - rb, m_sent.size() - sb);
        else checks_passed++;
        for (int i = 0; rb + i < rx_q.size() && sb + i < m_sent.size(); i++) begin
            checks_total++;
            if (rx_q[rb+i] !== m_sent[sb+i])
                $display("[TB] FAIL rand_order[%0d]: got %h expected %h", i, rx_q[rb+i], m_sent[sb+i]);
            else checks_passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_pop_edge();
        test_reset_mid_frame();
        test_pointer_wrap();
        test_random_traffic();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
